// File: rtl/cv32e40x_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// cv32e40x_rvfi_trace_buffer
//   Capture buffer for retired-instruction trace records. Up to NRET
//   retirements per cycle are packed into a DEPTH-entry circular buffer and
//   drained over a valid/ready port.
//   MODE=0 : stream FIFO, lanes that do not fit are dropped and counted.
//   MODE=1 : history buffer, overwrites oldest while capturing, freezes
//            POST_TRIG records after trigger_i, then is read oldest-first.
//
//   Optional feature (macro CV32E40X_RVFI_TRACE_FILTER_EN): adds filt_lo_i /
//   filt_hi_i; only lanes with filt_lo_i <= pc <= filt_hi_i are captured.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rvfi_*              per-lane retire strobe and trace fields (NRET lanes)
//   trigger_i           history-mode trigger pulse
//   clear_i             synchronous flush (overrides write/pop/trigger)
//   rec_valid_o/ready_i head record handshake
//   rec_data_o          {pc, rd_addr, rd_wdata, rmask, wmask}, 0 when empty
//   level_o             occupancy 0..DEPTH
//   drop_cnt_o          stream-mode lost records, saturating
//   frozen_o            history capture stopped
// ---------------------------------------------------------------------------

// Per-lane record packing and capture eligibility.
module cv32e40x_rvfi_trace_buffer_lane #(
  parameter int unsigned REC_W = 77
) (
  input  logic             i_valid,
  input  logic [31:0]      i_pc,
  input  logic [4:0]       i_rd_addr,
  input  logic [31:0]      i_rd_wdata,
  input  logic [3:0]       i_rmask,
  input  logic [3:0]       i_wmask,
`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
  input  logic [31:0]      i_filt_lo,
  input  logic [31:0]      i_filt_hi,
`endif
  output logic             o_elig,
  output logic [REC_W-1:0] o_rec
);
  logic w_in_range;

`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
  // lo > hi gives an empty window, so nothing is captured.
  assign w_in_range = (i_pc >= i_filt_lo) && (i_pc <= i_filt_hi);
`else
  assign w_in_range = 1'b1;
`endif

  assign o_elig = i_valid && w_in_range;
  assign o_rec  = {i_pc, i_rd_addr, i_rd_wdata, i_rmask, i_wmask};
endmodule

module cv32e40x_rvfi_trace_buffer #(
  parameter  int unsigned NRET      = 1,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned MODE      = 0,
  parameter  int unsigned POST_TRIG = 8,
  parameter  int unsigned REC_W     = 77,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [32*NRET-1:0]   rvfi_pc_rdata,
  input  logic [5*NRET-1:0]    rvfi_rd_addr,
  input  logic [32*NRET-1:0]   rvfi_rd_wdata,
  input  logic [4*NRET-1:0]    rvfi_mem_rmask,
  input  logic [4*NRET-1:0]    rvfi_mem_wmask,
`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
  input  logic [31:0]          filt_lo_i,
  input  logic [31:0]          filt_hi_i,
`endif
  input  logic                 trigger_i,
  input  logic                 clear_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [REC_W-1:0]     rec_data_o,
  output logic [AW:0]          level_o,
  output logic [15:0]          drop_cnt_o,
  output logic                 frozen_o
);

  typedef enum logic [1:0] {S_CAPTURE, S_POST, S_FROZEN} state_e;

  state_e                       r_state, w_state_nxt;
  logic [REC_W-1:0]             r_mem [DEPTH];
  logic [AW-1:0]                r_head, r_tail, r_cnt;
  logic [AW:0]                  r_level;
  logic [15:0]                  r_drop;

  logic [NRET-1:0]              w_elig, w_acc;
  logic [NRET-1:0][REC_W-1:0]   w_rec;
  logic [NRET-1:0][AW-1:0]      w_waddr;
  logic [AW:0]                  w_free, w_limit, w_n_elig, w_n_acc, w_n_drop;
  logic [AW:0]                  w_sum, w_ovf, w_level_nxt;
  logic [AW-1:0]                w_head_nxt, w_tail_nxt, w_cnt_nxt;
  logic [16:0]                  w_drop_sum;
  logic [15:0]                  w_drop_nxt;
  logic                         w_pop;

  // ---- lanes ----
  for (genvar l = 0; l < NRET; l++) begin : g_lane
    cv32e40x_rvfi_trace_buffer_lane #(.REC_W(REC_W)) u_lane (
      .i_valid    (rvfi_valid[l]),
      .i_pc       (rvfi_pc_rdata[32*l +: 32]),
      .i_rd_addr  (rvfi_rd_addr[5*l +: 5]),
      .i_rd_wdata (rvfi_rd_wdata[32*l +: 32]),
      .i_rmask    (rvfi_mem_rmask[4*l +: 4]),
      .i_wmask    (rvfi_mem_wmask[4*l +: 4]),
`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
      .i_filt_lo  (filt_lo_i),
      .i_filt_hi  (filt_hi_i),
`endif
      .o_elig     (w_elig[l]),
      .o_rec      (w_rec[l])
    );
  end

  // ---- lane acceptance ----
  // w_limit is how many eligible lanes may be written this cycle. Accepted
  // lanes are always a prefix of the eligible lanes in lane order and are
  // packed into consecutive slots starting at the tail.
  always_comb begin
    w_free = (AW+1)'(DEPTH) - r_level;
    if (MODE == 0) begin
      w_limit = w_free;
    end else begin
      unique case (r_state)
        S_CAPTURE: w_limit = (AW+1)'(NRET);
        S_POST:    w_limit = {1'b0, r_cnt};
        default:   w_limit = '0;
      endcase
    end
    w_n_elig = '0;
    w_n_acc  = '0;
    w_acc    = '0;
    w_waddr  = '0;
    for (int l = 0; l < NRET; l++) begin
      w_waddr[l] = AW'({1'b0, r_tail} + w_n_acc);
      if (w_elig[l]) begin
        if (w_n_elig < w_limit) begin
          w_acc[l] = 1'b1;
          w_n_acc  = w_n_acc + (AW+1)'(1);
        end
        w_n_elig = w_n_elig + (AW+1)'(1);
      end
    end
    // Lanes cut off by the post-trigger count are discarded silently.
    w_n_drop = (MODE == 0) ? (w_n_elig - w_n_acc) : '0;
  end

  // ---- pointers / level / drop counter ----
  always_comb begin
    w_pop = rec_valid_o && rec_ready_i;
    w_sum = r_level + w_n_acc;
    // History capture overwrites the oldest entries: head follows tail.
    w_ovf = (MODE != 0 && w_sum > (AW+1)'(DEPTH)) ? (w_sum - (AW+1)'(DEPTH)) : '0;
    w_level_nxt = w_sum - w_ovf - (AW+1)'(w_pop);
    w_head_nxt  = AW'({1'b0, r_head} + w_ovf + (AW+1)'(w_pop));
    w_tail_nxt  = AW'({1'b0, r_tail} + w_n_acc);
    w_drop_sum  = {1'b0, r_drop} + 17'(w_n_drop);
    w_drop_nxt  = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_drop  <= '0;
    end else if (clear_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_drop  <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_level <= w_level_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Storage is not reset; only entries below level_o are ever visible.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NRET; l++) begin
      if (w_acc[l] && !clear_i) r_mem[w_waddr[l]] <= w_rec[l];
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CAPTURE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---- FSM: next state ----
  // Trigger-cycle records are written but not counted against POST_TRIG.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (MODE != 0) begin
      unique case (r_state)
        S_CAPTURE: begin
          if (trigger_i) begin
            w_cnt_nxt   = AW'(POST_TRIG);
            w_state_nxt = (POST_TRIG == 0) ? S_FROZEN : S_POST;
          end
        end
        S_POST: begin
          w_cnt_nxt = AW'({1'b0, r_cnt} - w_n_acc);
          if (w_n_acc == {1'b0, r_cnt}) w_state_nxt = S_FROZEN;
        end
        default: ;
      endcase
    end
    if (clear_i) begin
      w_state_nxt = S_CAPTURE;
      w_cnt_nxt   = '0;
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    frozen_o    = (r_state == S_FROZEN);
    rec_valid_o = (r_level != '0) && ((MODE == 0) || (r_state == S_FROZEN));
    rec_data_o  = (r_level != '0) ? r_mem[r_head] : '0;
    level_o     = r_level;
    drop_cnt_o  = r_drop;
  end

endmodule

// File: tb/tb_cv32e40x_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// Bench for cv32e40x_rvfi_trace_buffer. Two instances:
//   u_s : stream,  NRET=2, DEPTH=4
//   u_h : history, NRET=2, DEPTH=8, POST_TRIG=2
// Record fields are derived from the pc so a whole record can be predicted.
// ---------------------------------------------------------------------------
module tb_cv32e40x_rvfi_trace_buffer;
  localparam int RW = 77;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // stream instance signals
  logic [1:0]    s_valid;
  logic [63:0]   s_pc, s_wd;
  logic [9:0]    s_rd;
  logic [7:0]    s_rm, s_wm;
  logic          s_trig, s_clr, s_rdy, s_rv, s_frz;
  logic [RW-1:0] s_data;
  logic [2:0]    s_lvl;
  logic [15:0]   s_drop;

  // history instance signals
  logic [1:0]    h_valid;
  logic [63:0]   h_pc, h_wd;
  logic [9:0]    h_rd;
  logic [7:0]    h_rm, h_wm;
  logic          h_trig, h_clr, h_rdy, h_rv, h_frz;
  logic [RW-1:0] h_data;
  logic [3:0]    h_lvl;
  logic [15:0]   h_drop;

`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
  logic [31:0] f_lo = 32'h0;
  logic [31:0] f_hi = 32'hFFFF_FFFF;
`endif

  cv32e40x_rvfi_trace_buffer #(.NRET(2), .DEPTH(4), .MODE(0), .POST_TRIG(0)) u_s (
    .clk(clk), .rst_n(rst_n),
    .rvfi_valid(s_valid), .rvfi_pc_rdata(s_pc), .rvfi_rd_addr(s_rd),
    .rvfi_rd_wdata(s_wd), .rvfi_mem_rmask(s_rm), .rvfi_mem_wmask(s_wm),
`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
    .filt_lo_i(f_lo), .filt_hi_i(f_hi),
`endif
    .trigger_i(s_trig), .clear_i(s_clr),
    .rec_valid_o(s_rv), .rec_ready_i(s_rdy), .rec_data_o(s_data),
    .level_o(s_lvl), .drop_cnt_o(s_drop), .frozen_o(s_frz)
  );

  cv32e40x_rvfi_trace_buffer #(.NRET(2), .DEPTH(8), .MODE(1), .POST_TRIG(2)) u_h (
    .clk(clk), .rst_n(rst_n),
    .rvfi_valid(h_valid), .rvfi_pc_rdata(h_pc), .rvfi_rd_addr(h_rd),
    .rvfi_rd_wdata(h_wd), .rvfi_mem_rmask(h_rm), .rvfi_mem_wmask(h_wm),
`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
    .filt_lo_i(32'h0), .filt_hi_i(32'hFFFF_FFFF),
`endif
    .trigger_i(h_trig), .clear_i(h_clr),
    .rec_valid_o(h_rv), .rec_ready_i(h_rdy), .rec_data_o(h_data),
    .level_o(h_lvl), .drop_cnt_o(h_drop), .frozen_o(h_frz)
  );

  logic [31:0] sq[$];  // expected stream readout order
  logic [31:0] hq[$];  // expected history readout order

  function automatic logic [RW-1:0] mkrec(input logic [31:0] pc);
    return {pc, pc[6:2], ~pc, pc[3:0], pc[7:4]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic s_drive(input logic [1:0] v, input logic [31:0] p0, p1,
                         input logic rdy, clr);
    s_valid = v;        s_pc = {p1, p0};  s_wd = {~p1, ~p0};
    s_rd = {p1[6:2], p0[6:2]};  s_rm = {p1[3:0], p0[3:0]};
    s_wm = {p1[7:4], p0[7:4]};  s_rdy = rdy;  s_clr = clr;
    s_trig = v[0];      // must have no effect in stream mode
  endtask

  task automatic h_drive(input logic [1:0] v, input logic [31:0] p0, p1,
                         input logic trig, rdy, clr);
    h_valid = v;        h_pc = {p1, p0};  h_wd = {~p1, ~p0};
    h_rd = {p1[6:2], p0[6:2]};  h_rm = {p1[3:0], p0[3:0]};
    h_wm = {p1[7:4], p0[7:4]};  h_trig = trig;  h_rdy = rdy;  h_clr = clr;
  endtask

  // One cycle: drive, check any pop against the scoreboard, record the
  // lanes expected to be stored, then clock.
  task automatic s_step(input logic [1:0] v, input logic [31:0] p0, p1,
                        input logic rdy, clr, input logic [1:0] keep);
    logic [31:0] e;
    @(negedge clk);
    s_drive(v, p0, p1, rdy, clr);
    #1;
    if (clr) sq.delete();
    else if (s_rv && rdy) begin
      if (sq.size() == 0) begin
        n_chk++;
        $display("FAIL s_pop: got %0h expected no record", s_data);
      end else begin
        e = sq.pop_front();
        chk("s_pop", s_data, mkrec(e));
      end
    end
    if (!clr && keep[0]) sq.push_back(p0);
    if (!clr && keep[1]) sq.push_back(p1);
    @(posedge clk);
    #1;
  endtask

  task automatic h_step(input logic [1:0] v, input logic [31:0] p0, p1,
                        input logic trig, rdy, clr);
    logic [31:0] e;
    @(negedge clk);
    h_drive(v, p0, p1, trig, rdy, clr);
    #1;
    if (clr) hq.delete();
    else if (h_rv && rdy) begin
      if (hq.size() == 0) begin
        n_chk++;
        $display("FAIL h_pop: got %0h expected no record", h_data);
      end else begin
        e = hq.pop_front();
        chk("h_pop", h_data, mkrec(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic s_chk(input string t, input int lvl, input int drop);
    chk({t, "_lvl"}, s_lvl, lvl);
    chk({t, "_drop"}, s_drop, drop);
    chk({t, "_valid"}, s_rv, (lvl != 0));
    chk({t, "_frozen"}, s_frz, 0);
    if (lvl == 0) chk({t, "_data0"}, s_data, 0);
  endtask

  task automatic h_chk(input string t, input int lvl, input logic frz);
    chk({t, "_lvl"}, h_lvl, lvl);
    chk({t, "_frozen"}, h_frz, frz);
    chk({t, "_valid"}, h_rv, (frz && lvl != 0));
    chk({t, "_drop"}, h_drop, 0);
    if (lvl == 0) chk({t, "_data0"}, h_data, 0);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] p0, p1;
    logic        rdy, clr;
    logic [1:0]  keep;
    int          lvl, drop;
  } s_vec_t;

  initial begin
    s_vec_t tv[$];

    // stream vectors: {valid, pc0, pc1, ready, clear, stored lanes, level, drops}
    tv.push_back('{2'b01, 32'h100, 32'h0,   1'b0, 1'b0, 2'b01, 1, 0});
    tv.push_back('{2'b01, 32'h104, 32'h0,   1'b0, 1'b0, 2'b01, 2, 0});
    tv.push_back('{2'b01, 32'h108, 32'h0,   1'b0, 1'b0, 2'b01, 3, 0});
    tv.push_back('{2'b01, 32'h10C, 32'h0,   1'b0, 1'b0, 2'b01, 4, 0});
    tv.push_back('{2'b01, 32'h110, 32'h0,   1'b0, 1'b0, 2'b00, 4, 1});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 3, 1});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 2, 1});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 1, 1});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 0, 1});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 0, 1});
    tv.push_back('{2'b11, 32'h1F0, 32'h1F4, 1'b0, 1'b0, 2'b11, 2, 1});
    tv.push_back('{2'b01, 32'h1F8, 32'h0,   1'b0, 1'b0, 2'b01, 3, 1});
    tv.push_back('{2'b11, 32'h200, 32'h204, 1'b1, 1'b0, 2'b01, 3, 2});
    tv.push_back('{2'b10, 32'h0,   32'h300, 1'b0, 1'b0, 2'b10, 4, 2});
    tv.push_back('{2'b11, 32'h310, 32'h314, 1'b0, 1'b0, 2'b00, 4, 4});
    tv.push_back('{2'b11, 32'h320, 32'h324, 1'b1, 1'b1, 2'b00, 0, 0});
    tv.push_back('{2'b11, 32'h400, 32'h404, 1'b0, 1'b0, 2'b11, 2, 0});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 1, 0});
    tv.push_back('{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 2'b00, 0, 0});

    s_drive(2'b00, 0, 0, 1'b0, 1'b0);
    h_drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    s_chk("rst_s", 0, 0);
    h_chk("rst_h", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- stream: table ----
    for (int i = 0; i < tv.size(); i++) begin
      s_step(tv[i].v, tv[i].p0, tv[i].p1, tv[i].rdy, tv[i].clr, tv[i].keep);
      s_chk($sformatf("s_vec%0d", i), tv[i].lvl, tv[i].drop);
    end
    chk("s_sb_empty", sq.size(), 0);

    // ---- stream: drop counter saturation ----
    for (int i = 0; i < 32769; i++) s_step(2'b11, 32'h500, 32'h504, 1'b0, 1'b0, 2'b00);
    s_chk("s_sat_m1", 4, 16'hFFFE);
    s_step(2'b11, 32'h500, 32'h504, 1'b0, 1'b0, 2'b00);
    s_chk("s_sat", 4, 16'hFFFF);
    s_step(2'b11, 32'h500, 32'h504, 1'b0, 1'b0, 2'b00);
    s_chk("s_sat_hold", 4, 16'hFFFF);
    s_step(2'b00, 0, 0, 1'b0, 1'b1, 2'b00);
    s_chk("s_sat_clr", 0, 0);

`ifdef CV32E40X_RVFI_TRACE_FILTER_EN
    // ---- stream: pc window filter ----
    f_lo = 32'h1000; f_hi = 32'h1FFF;
    s_step(2'b11, 32'h0FFC, 32'h1000, 1'b0, 1'b0, 2'b10);
    s_chk("f_a", 1, 0);
    s_step(2'b11, 32'h1FFC, 32'h2000, 1'b0, 1'b0, 2'b01);
    s_chk("f_b", 2, 0);
    s_step(2'b00, 0, 0, 1'b1, 1'b0, 2'b00);
    s_step(2'b00, 0, 0, 1'b1, 1'b0, 2'b00);
    s_chk("f_drain", 0, 0);
    f_lo = 32'h2000; f_hi = 32'h1000;
    s_step(2'b11, 32'h1800, 32'h1804, 1'b0, 1'b0, 2'b00);
    s_chk("f_empty_win", 0, 0);
    f_lo = 32'h0; f_hi = 32'hFFFF_FFFF;
`endif

    @(negedge clk);
    s_drive(2'b00, 0, 0, 1'b0, 1'b0);

    // ---- history: 16 retirements, trigger on pc 0x28, ready ignored ----
    for (int k = 0; k < 16; k++) begin
      h_step(2'b01, 32'(4 * k), 32'h0, (k == 10), (k <= 12), 1'b0);
      h_chk($sformatf("h_cap%0d", k), (k + 1 > 8) ? 8 : k + 1, (k >= 12));
    end
    for (int k = 5; k <= 12; k++) hq.push_back(32'(4 * k));
    for (int k = 0; k < 3; k++) begin
      h_step(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
      h_chk($sformatf("h_rd%0d", k), 7 - k, 1'b1);
    end

    // clear with ready, write and trigger in the same cycle: clear wins
    h_step(2'b11, 32'h90, 32'h94, 1'b1, 1'b1, 1'b1);
    h_chk("h_clr", 0, 1'b0);
    h_step(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    h_chk("h_clr_idle", 0, 1'b0);

    // ---- history: two-lane partial decrement ----
    h_step(2'b11, 32'hA0, 32'hA4, 1'b0, 1'b0, 1'b0);
    h_chk("h_p0", 2, 1'b0);
    h_step(2'b11, 32'hA8, 32'hAC, 1'b1, 1'b0, 1'b0);
    h_chk("h_p1", 4, 1'b0);
    h_step(2'b01, 32'hB0, 32'h0, 1'b0, 1'b0, 1'b0);
    h_chk("h_p2", 5, 1'b0);
    h_step(2'b11, 32'hB4, 32'hB8, 1'b1, 1'b0, 1'b0);
    h_chk("h_p3", 6, 1'b1);
    h_step(2'b11, 32'hC0, 32'hC4, 1'b0, 1'b0, 1'b0);
    h_chk("h_p4", 6, 1'b1);
    hq.push_back(32'hA0); hq.push_back(32'hA4); hq.push_back(32'hA8);
    hq.push_back(32'hAC); hq.push_back(32'hB0); hq.push_back(32'hB4);
    for (int k = 0; k < 6; k++) begin
      h_step(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
      h_chk($sformatf("h_pd%0d", k), 5 - k, 1'b1);
    end
    chk("h_sb_empty", hq.size(), 0);

    // ---- history: asynchronous reset mid-POST ----
    h_step(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    h_chk("h_r_clr", 0, 1'b0);
    h_step(2'b11, 32'hD0, 32'hD4, 1'b0, 1'b0, 1'b0);
    h_step(2'b11, 32'hD8, 32'hDC, 1'b0, 1'b0, 1'b0);
    h_step(2'b01, 32'hE0, 32'h0, 1'b0, 1'b0, 1'b0);
    h_step(2'b01, 32'hE4, 32'h0, 1'b1, 1'b0, 1'b0);
    h_chk("h_r_pre", 6, 1'b0);
    @(negedge clk);
    h_drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    h_chk("h_r_async", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    h_step(2'b01, 32'hF0, 32'h0, 1'b1, 1'b0, 1'b0);
    h_chk("h_r_t", 1, 1'b0);
    h_step(2'b01, 32'hF4, 32'h0, 1'b0, 1'b0, 1'b0);
    h_chk("h_r_p1", 2, 1'b0);
    h_step(2'b01, 32'hF8, 32'h0, 1'b0, 1'b0, 1'b0);
    h_chk("h_r_p2", 3, 1'b1);
    hq.push_back(32'hF0); hq.push_back(32'hF4); hq.push_back(32'hF8);
    for (int k = 0; k < 3; k++) begin
      h_step(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
      h_chk($sformatf("h_rr%0d", k), 2 - k, 1'b1);
    end
    chk("h_sb_empty2", hq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
